// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen : VGA counters, blanking flags and latency-aligned sync/RGB.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LAT      = 2
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] pixel_rgb,
  output logic       px_en,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       frame_start,
  output logic       vblank,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [7:0] vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]     h_cnt;
  logic [9:0]     v_cnt;
  logic [9:0]     h_nxt;
  logic [9:0]     v_nxt;
  logic           started;
  logic           hs_raw;
  logic           vs_raw;
  logic [LAT:0]   hs_pipe;
  logic [LAT:0]   vs_pipe;
  logic [LAT-1:0] act_pipe;

  // The first enabled edge after reset presents (0,0) rather than advancing past it.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (started) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
      end
    end
  end

  always_comb begin
    hs_raw = !(en && (h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw = !(en && (v_cnt >= VS_BEG) && (v_cnt < VS_END));
  end

  // Flags are computed from the next position so they line up with x_pos/y_pos.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      started     <= 1'b0;
      px_en       <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      started     <= 1'b1;
      px_en       <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      vblank      <= (v_nxt >= V_ACT);
    end else begin
      px_en       <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      act_pipe <= '0;
      vga_rgb  <= 8'h00;
    end else begin
      hs_pipe     <= {hs_pipe[LAT-1:0], hs_raw};
      vs_pipe     <= {vs_pipe[LAT-1:0], vs_raw};
      act_pipe[0] <= px_en;
      for (int i = 1; i < LAT; i++) begin
        act_pipe[i] <= act_pipe[i-1];
      end
      vga_rgb <= act_pipe[LAT-1] ? pixel_rgb : 8'h00;
    end
  end

  assign x_pos  = h_cnt;
  assign y_pos  = v_cnt;
  assign vga_hs = hs_pipe[LAT];
  assign vga_vs = vs_pipe[LAT];

endmodule

`default_nettype wire
